// File: rtl/dsi_lanes_sequencer.sv
// dsi_lanes_sequencer: power/clock sequencer for N_LANES MIPI-DSI data lanes
// plus the clock lane. It drives the LP buffer enables and the clock-lane
// start/finish requests, with timed settle windows, a clock-lane timeout that
// sets a sticky error, and draining of the data lanes before the clock stops.
// Optional feature macro: DSI_ULPS_EN (adds ULPS entry/exit states).
module dsi_lanes_sequencer #(
    parameter int N_LANES  = 4,
    parameter int T_SETTLE = 16,
    parameter int CLK_TMO  = 1023,
    parameter int LN_W     = ($clog2(N_LANES) > 0) ? $clog2(N_LANES) : 1
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic               lines_enable,
    input  logic               clock_enable,
    input  logic [LN_W-1:0]    reg_lanes_number,
    input  logic               clk_lane_active,
    input  logic [N_LANES-1:0] lanes_active,
    input  logic               ulps_rqst,
    output logic [N_LANES-1:0] lane_lines_enable,
    output logic               clk_lines_enable,
    output logic               clk_lane_start,
    output logic               clk_lane_fin,
    output logic               lines_ready,
    output logic               clock_ready,
    output logic               clk_tmo_err,
    output logic               ulps_active
);

    localparam int CNT_MAX_V = (T_SETTLE > CLK_TMO) ? T_SETTLE : CLK_TMO;
    localparam int CW        = $clog2(CNT_MAX_V + 1);
    localparam logic [CW-1:0] SETTLE_END = CW'(T_SETTLE - 1);
    localparam logic [CW-1:0] TMO_END    = CW'(CLK_TMO);

`ifdef DSI_ULPS_EN
    typedef enum logic [3:0] {
        ST_IDLE, ST_EN_BUF, ST_READY, ST_CLK_ON, ST_ACTIVE, ST_DRAIN,
        ST_CLK_OFF, ST_DIS_BUF, ST_ULPS_ENT, ST_ULPS, ST_ULPS_EXIT
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_EN_BUF, ST_READY, ST_CLK_ON, ST_ACTIVE, ST_DRAIN,
        ST_CLK_OFF, ST_DIS_BUF
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_LANES-1:0] mask_q, mask_d;
    logic               tmo_err_q, tmo_err_d;
    logic [N_LANES-1:0] lane_mask;

`ifndef DSI_ULPS_EN
    logic unused_ulps_rqst;
    assign unused_ulps_rqst = ulps_rqst;
`endif

    // Thermometer mask of lanes 0..reg_lanes_number; oversize values saturate to all ones
    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            lane_mask[i] = (i <= 32'(reg_lanes_number));
        end
    end

    // State, counter, lane mask and sticky error registers
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    // Next-state logic; the counter restarts from zero on every state change
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        tmo_err_d = tmo_err_q;
        case (state_q)
            ST_IDLE: begin
                if (lines_enable) begin
                    state_d   = ST_EN_BUF;
                    mask_d    = lane_mask;
                    tmo_err_d = 1'b0;
                end
            end
            ST_EN_BUF: begin
                if (cnt_q == SETTLE_END) state_d = ST_READY;
            end
            ST_READY: begin
                if (!lines_enable)     state_d = ST_DIS_BUF;
                else if (clock_enable) state_d = ST_CLK_ON;
`ifdef DSI_ULPS_EN
                else if (ulps_rqst)    state_d = ST_ULPS_ENT;
`endif
            end
            ST_CLK_ON: begin
                if (clk_lane_active) begin
                    state_d = ST_ACTIVE;
                end else if (cnt_q == TMO_END) begin
                    state_d   = ST_READY;
                    tmo_err_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!clock_enable) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (clock_enable)                      state_d = ST_ACTIVE;
                else if ((lanes_active & mask_q) == '0) state_d = ST_CLK_OFF;
            end
            ST_CLK_OFF: begin
                if (!clk_lane_active) begin
                    state_d = ST_READY;
                end else if (cnt_q == TMO_END) begin
                    state_d   = ST_READY;
                    tmo_err_d = 1'b1;
                end
            end
            ST_DIS_BUF: begin
                if (cnt_q == SETTLE_END) state_d = ST_IDLE;
            end
`ifdef DSI_ULPS_EN
            ST_ULPS_ENT: begin
                state_d = ST_ULPS;
            end
            ST_ULPS: begin
                if (!ulps_rqst || !lines_enable) state_d = ST_ULPS_EXIT;
            end
            ST_ULPS_EXIT: begin
                if (cnt_q == SETTLE_END) state_d = ST_READY;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q == '1)    cnt_d = cnt_q;
        else                     cnt_d = cnt_q + 1'b1;
    end

    // Outputs decoded from registered state, so reset clears them at once
    always_comb begin
        lane_lines_enable = '0;
        clk_lines_enable  = 1'b0;
        clk_lane_start    = 1'b0;
        clk_lane_fin      = 1'b0;
        lines_ready       = 1'b0;
        clock_ready       = 1'b0;
        ulps_active       = 1'b0;
        clk_tmo_err       = tmo_err_q;
        case (state_q)
            ST_IDLE: ;
`ifdef DSI_ULPS_EN
            ST_ULPS: ulps_active = 1'b1;
`endif
            default: begin
                lane_lines_enable = mask_q;
                clk_lines_enable  = 1'b1;
            end
        endcase
        case (state_q)
            ST_READY:   lines_ready = 1'b1;
            ST_CLK_ON: begin
                lines_ready    = 1'b1;
                clk_lane_start = 1'b1;
            end
            ST_ACTIVE: begin
                lines_ready = 1'b1;
                clock_ready = 1'b1;
            end
            ST_DRAIN:   lines_ready = 1'b1;
            ST_CLK_OFF: begin
                lines_ready  = 1'b1;
                clk_lane_fin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
